// File: rtl/shifter_pipe_if.sv
// Request/result bundle for shifter_pipe.
//
// Handshake: a request (a, shamt, op) is taken on a rising clk edge when
// in_valid=1 and stall=0. stall=1 freezes the pipe, and the inputs on that
// edge are ignored. out_valid qualifies y, zero and carry. There is no
// backpressure other than stall.
interface shifter_pipe_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
);
    logic             stall;
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [SHW-1:0]   shamt;
    logic [1:0]       op;
    logic             out_valid;
    logic [WIDTH-1:0] y;
    logic             zero;
    logic             carry;

    // The requester drives operands and stall, and observes results.
    modport master (
        output stall, in_valid, a, shamt, op,
        input  out_valid, y, zero, carry
    );

    // The shifter consumes operands and stall, and drives results.
    modport slave (
        input  stall, in_valid, a, shamt, op,
        output out_valid, y, zero, carry
    );
endinterface

// File: rtl/shifter_pipe.sv
// Two-stage pipelined log shifter (SLL/SRL/SRA/ROTR) with zero/carry flags.
// Stage 1 registers the request. Stage 2 registers the shifted result.
// A global stall holds both stages.
module shifter_pipe #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    shifter_pipe_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_ROTR = 2'b11;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q,     s1_a_d;
    logic [SHW-1:0]   s1_shamt_q, s1_shamt_d;
    logic [1:0]       s1_op_q,    s1_op_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] y_q,         y_d;
    logic             zero_q,      zero_d;
    logic             carry_q,     carry_d;

    logic [WIDTH-1:0] shift_res;
    logic [SHW-1:0]   carry_idx;
    logic             shift_carry;

    // Stage 1: capture the request unless stalled.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_shamt_d = s1_shamt_q;
        s1_op_d    = s1_op_q;
        if (!bus.stall) begin
            s1_valid_d = bus.in_valid;
            s1_a_d     = bus.a;
            s1_shamt_d = bus.shamt;
            s1_op_d    = bus.op;
        end
    end

    // Log shifter: level k moves the data by 2^k when shamt[k] is set.
    always_comb begin
        shift_res = s1_a_q;
        for (int k = 0; k < SHW; k++) begin
            if (s1_shamt_q[k]) begin
                case (s1_op_q)
                    OP_SLL:  shift_res = shift_res << (2 ** k);
                    OP_SRL:  shift_res = shift_res >> (2 ** k);
                    OP_SRA:  shift_res = WIDTH'($signed(shift_res) >>> (2 ** k));
                    default: shift_res = (shift_res >> (2 ** k)) |
                                         (shift_res << (WIDTH - 2 ** k));
                endcase
            end
        end
    end

    // Carry is the last bit shifted out. For SLL, WIDTH-shamt equals -shamt
    // modulo 2^SHW because WIDTH is a power of two, so the index never overflows.
    always_comb begin
        if (s1_op_q == OP_SLL) begin
            carry_idx = SHW'(0) - s1_shamt_q;
        end else begin
            carry_idx = s1_shamt_q - SHW'(1);
        end
        shift_carry = (s1_shamt_q == '0) ? 1'b0 : s1_a_q[carry_idx];
    end

    // Stage 2: register the result and flags unless stalled.
    always_comb begin
        out_valid_d = out_valid_q;
        y_d         = y_q;
        zero_d      = zero_q;
        carry_d     = carry_q;
        if (!bus.stall) begin
            out_valid_d = s1_valid_q;
            y_d         = shift_res;
            zero_d      = (shift_res == '0);
            carry_d     = shift_carry;
        end
    end

    // Pipeline registers. Reset takes priority over stall and drops in-flight work.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_shamt_q  <= '0;
            s1_op_q     <= '0;
            out_valid_q <= 1'b0;
            y_q         <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_shamt_q  <= s1_shamt_d;
            s1_op_q     <= s1_op_d;
            out_valid_q <= out_valid_d;
            y_q         <= y_d;
            zero_q      <= zero_d;
            carry_q     <= carry_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.y         = y_q;
    assign bus.zero      = zero_q;
    assign bus.carry     = carry_q;
endmodule
